// File: rtl/peripheral_spram_tl_req_queue_pkg.sv
// Shared BIU types for the SPRAM TileLink request path: burst-type encoding
// and the packed request entry held in the request FIFO.
package peripheral_biu_pkg;

   localparam int BIU_XLEN_MAX = 64;
   localparam int BIU_PLEN_MAX = 64;

   typedef enum logic [2:0] {
      SINGLE = 3'b000,
      INCR   = 3'b001,
      WRAP4  = 3'b010,
      INCR4  = 3'b011,
      WRAP8  = 3'b100,
      INCR8  = 3'b101
   } biu_type_t;

   // Fields are sized for the widest supported bus; narrower buses use the low bits.
   typedef struct packed {
      logic                    we;
      logic [BIU_PLEN_MAX-1:0] adr;
      logic [2:0]              size;
      logic [2:0]              prot;
      logic                    lock;
      logic [BIU_XLEN_MAX-1:0] d;
   } req_entry_t;

endpackage

// File: rtl/peripheral_spram_tl_req_queue_if.sv
// Core request/response and BIU strobe bus of the SPRAM TL request queue.
interface peripheral_spram_tl_req_queue_if #(
   parameter int XLEN = 64,
   parameter int PLEN = 64
);
   logic            req_valid_i;
   logic            req_ready_o;
   logic            req_we_i;
   logic [PLEN-1:0] req_adr_i;
   logic [2:0]      req_size_i;
   logic [2:0]      req_prot_i;
   logic            req_lock_i;
   logic [XLEN-1:0] req_d_i;
   logic            rsp_valid_o;
   logic [XLEN-1:0] rsp_q_o;
   logic            rsp_err_o;
   logic            biu_stb_o;
   logic            biu_stb_ack_i;
   logic            biu_d_ack_i;
   logic [PLEN-1:0] biu_adri_o;
   logic [2:0]      biu_size_o;
   logic [2:0]      biu_type_o;
   logic [2:0]      biu_prot_o;
   logic            biu_lock_o;
   logic            biu_we_o;
   logic [XLEN-1:0] biu_d_o;
   logic [XLEN-1:0] biu_q_i;
   logic            biu_ack_i;
   logic            biu_err_i;

   modport master (
      input  req_valid_i, req_we_i, req_adr_i, req_size_i, req_prot_i, req_lock_i, req_d_i,
      output req_ready_o, rsp_valid_o, rsp_q_o, rsp_err_o,
      output biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_prot_o, biu_lock_o,
             biu_we_o, biu_d_o,
      input  biu_stb_ack_i, biu_d_ack_i, biu_q_i, biu_ack_i, biu_err_i
   );

   modport slave (
      output req_valid_i, req_we_i, req_adr_i, req_size_i, req_prot_i, req_lock_i, req_d_i,
      input  req_ready_o, rsp_valid_o, rsp_q_o, rsp_err_o,
      input  biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_prot_o, biu_lock_o,
             biu_we_o, biu_d_o,
      output biu_stb_ack_i, biu_d_ack_i, biu_q_i, biu_ack_i, biu_err_i
   );

endinterface

// File: rtl/peripheral_spram_tl_req_fifo.sv
// Generic synchronous FIFO with registered occupancy count; pushes when full
// and pops when empty are ignored.
module peripheral_spram_tl_req_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst && do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/peripheral_spram_tl_req_queue.sv
// SPRAM TL BIU request stage: queues core requests, issues them on the
// stb/stb_ack handshake and returns in-order ack/err responses.
module peripheral_spram_tl_req_queue
   import peripheral_biu_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int PLEN    = 64,
   parameter int DEPTH   = 4,
   parameter int MAX_OUT = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   peripheral_spram_tl_req_queue_if.master   bus,
   output logic [2:0]                        outstanding_o,
   output logic                              proto_err_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);

   req_entry_t      push_entry;
   req_entry_t      head;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count_unused;
   logic            push;
   logic            pop;
   logic            lock_stall;
   logic            stb;
   logic            rsp_evt;
   logic            rsp_take;
   logic [2:0]      ins_idx;
   logic [7:0]      out_we;
   logic [7:0]      out_we_nxt;
   logic            unused_d_ack;

   assign unused_d_ack = bus.biu_d_ack_i;

   always_comb begin
      push_entry                = '0;
      push_entry.we             = bus.req_we_i;
      push_entry.adr[PLEN-1:0]  = bus.req_adr_i;
      push_entry.size           = bus.req_size_i;
      push_entry.prot           = bus.req_prot_i;
      push_entry.lock           = bus.req_lock_i;
      push_entry.d[XLEN-1:0]    = bus.req_d_i;
   end

   assign bus.req_ready_o = ~fifo_full;
   assign push            = bus.req_valid_i & ~fifo_full;

   peripheral_spram_tl_req_fifo #(
      .W     ($bits(req_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (push_entry),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count_unused)
   );

   // A locked head waits until everything already issued has completed.
   assign lock_stall = head.lock & (outstanding_o != 3'd0);
   assign stb        = ~fifo_empty & (outstanding_o < MAX_OUT_C) & ~lock_stall;
   assign pop        = stb & bus.biu_stb_ack_i;
   assign rsp_evt    = bus.biu_ack_i | bus.biu_err_i;
   assign rsp_take   = rsp_evt & (outstanding_o != 3'd0);

   always_comb begin
      bus.biu_stb_o  = stb;
      bus.biu_type_o = SINGLE;
      bus.biu_adri_o = '0;
      bus.biu_size_o = '0;
      bus.biu_prot_o = '0;
      bus.biu_lock_o = 1'b0;
      bus.biu_we_o   = 1'b0;
      bus.biu_d_o    = '0;
      if (stb) begin
         bus.biu_adri_o = head.adr[PLEN-1:0];
         bus.biu_size_o = head.size;
         bus.biu_prot_o = head.prot;
         bus.biu_lock_o = head.lock;
         bus.biu_we_o   = head.we;
         bus.biu_d_o    = head.d[XLEN-1:0];
      end
   end

   // out_we holds the write flag of each outstanding transfer, oldest in bit 0;
   // a same-cycle retire shifts first so the new entry lands after the survivors.
   assign ins_idx = outstanding_o - 3'(rsp_take);

   always_comb begin
      out_we_nxt = rsp_take ? (out_we >> 1) : out_we;
      if (pop) out_we_nxt[ins_idx] = head.we;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         outstanding_o   <= '0;
         out_we          <= '0;
         proto_err_o     <= 1'b0;
         bus.rsp_valid_o <= 1'b0;
         bus.rsp_q_o     <= '0;
         bus.rsp_err_o   <= 1'b0;
      end else begin
         outstanding_o   <= outstanding_o + 3'(pop) - 3'(rsp_take);
         out_we          <= out_we_nxt;
         bus.rsp_valid_o <= rsp_take;
         if (rsp_take) begin
            bus.rsp_err_o <= bus.biu_err_i;
            bus.rsp_q_o   <= (bus.biu_err_i | out_we[0]) ? '0 : bus.biu_q_i;
         end
         if (rsp_evt && outstanding_o == 3'd0) proto_err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_peripheral_spram_tl_req_queue.sv
// Scoreboard bench for peripheral_spram_tl_req_queue: directed scenarios then
// randomized traffic, checked against a queue-based reference model.
module tb_peripheral_spram_tl_req_queue;

   localparam int XLEN    = 64;
   localparam int PLEN    = 64;
   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] outstanding;
   logic       proto_err;

   always #5 clk = ~clk;

   peripheral_spram_tl_req_queue_if #(.XLEN(XLEN), .PLEN(PLEN)) bus ();

   peripheral_spram_tl_req_queue #(
      .XLEN    (XLEN),
      .PLEN    (PLEN),
      .DEPTH   (DEPTH),
      .MAX_OUT (MAX_OUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus.master),
      .outstanding_o (outstanding),
      .proto_err_o   (proto_err)
   );

   typedef struct {
      bit          we;
      logic [63:0] adr;
      logic [2:0]  size;
      logic [2:0]  prot;
      bit          lock;
      logic [63:0] d;
   } mreq_t;

   typedef struct {
      int unsigned due;
      logic [63:0] q;
      bit          err;
   } mrsp_t;

   mreq_t       m_fifo[$];
   bit          m_out[$];
   mrsp_t       exp_rsp[$];
   bit          m_proto;
   bit          after_reset;
   int unsigned cyc;
   int unsigned n_checks;
   int unsigned n_fail;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   // Monitor: compare DUT against model state, then advance the model by the
   // events that the coming rising edge will apply.
   always @(negedge clk) begin
      mreq_t e;
      mrsp_t r;
      bit    exp_ready, exp_stb, exp_v, w;
      cyc++;
      if (rst !== 1'b1) begin
         m_fifo.delete();
         m_out.delete();
         exp_rsp.delete();
         m_proto     = 1'b0;
         after_reset = 1'b1;
      end else begin
         exp_ready = (m_fifo.size() < DEPTH);
         exp_stb   = (m_fifo.size() > 0) && (m_out.size() < MAX_OUT) &&
                     !(m_fifo[0].lock && m_out.size() > 0);
         chk("req_ready", 64'(bus.req_ready_o), 64'(exp_ready));
         chk("biu_stb", 64'(bus.biu_stb_o), 64'(exp_stb));
         chk("outstanding", 64'(outstanding), 64'(m_out.size()));
         chk("proto_err", 64'(proto_err), 64'(m_proto));
         if (after_reset) begin
            chk("reset_rsp_q", bus.rsp_q_o, 64'd0);
            chk("reset_rsp_err", 64'(bus.rsp_err_o), 64'd0);
            chk("reset_biu_adr", bus.biu_adri_o, 64'd0);
            chk("reset_biu_d", bus.biu_d_o, 64'd0);
            chk("reset_biu_ctl", 64'({bus.biu_we_o, bus.biu_size_o, bus.biu_prot_o,
                                      bus.biu_lock_o, bus.biu_type_o}), 64'd0);
            after_reset = 1'b0;
         end
         if (bus.biu_stb_o && m_fifo.size() > 0) begin
            e = m_fifo[0];
            chk("biu_adr", bus.biu_adri_o, e.adr);
            chk("biu_d", bus.biu_d_o, e.d);
            chk("biu_ctl", 64'({bus.biu_we_o, bus.biu_size_o, bus.biu_prot_o, bus.biu_lock_o}),
                64'({e.we, e.size, e.prot, e.lock}));
            chk("biu_type", 64'(bus.biu_type_o), 64'd0);
         end
         exp_v = (exp_rsp.size() > 0) && (exp_rsp[0].due == cyc);
         chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(exp_v));
         if (exp_v) begin
            r = exp_rsp.pop_front();
            chk("rsp_q", bus.rsp_q_o, r.q);
            chk("rsp_err", 64'(bus.rsp_err_o), 64'(r.err));
         end

         if (bus.biu_ack_i || bus.biu_err_i) begin
            if (m_out.size() > 0) begin
               w     = m_out.pop_front();
               r.due = cyc + 1;
               r.err = bus.biu_err_i;
               r.q   = (bus.biu_err_i || w) ? 64'd0 : bus.biu_q_i;
               exp_rsp.push_back(r);
            end else begin
               m_proto = 1'b1;
            end
         end
         if (exp_stb && bus.biu_stb_ack_i) begin
            e = m_fifo.pop_front();
            m_out.push_back(e.we);
         end
         if (bus.req_valid_i && exp_ready) begin
            e.we   = bus.req_we_i;
            e.adr  = bus.req_adr_i;
            e.size = bus.req_size_i;
            e.prot = bus.req_prot_i;
            e.lock = bus.req_lock_i;
            e.d    = bus.req_d_i;
            m_fifo.push_back(e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.req_valid_i   = 1'b0;
      bus.req_we_i      = 1'b0;
      bus.req_adr_i     = '0;
      bus.req_size_i    = '0;
      bus.req_prot_i    = '0;
      bus.req_lock_i    = 1'b0;
      bus.req_d_i       = '0;
      bus.biu_stb_ack_i = 1'b0;
      bus.biu_d_ack_i   = 1'b0;
      bus.biu_q_i       = '0;
      bus.biu_ack_i     = 1'b0;
      bus.biu_err_i     = 1'b0;
   endtask

   task automatic set_req(input bit we, input logic [63:0] adr, input logic [63:0] d, input bit lock);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_adr_i   = adr;
      bus.req_size_i  = 3'd3;
      bus.req_prot_i  = 3'd2;
      bus.req_lock_i  = lock;
      bus.req_d_i     = d;
   endtask

   task automatic drain(input int unsigned n);
      bus.req_valid_i   = 1'b0;
      bus.biu_stb_ack_i = 1'b1;
      for (int unsigned i = 0; i < n; i++) begin
         bus.biu_ack_i = (m_out.size() > 0);
         bus.biu_q_i   = 64'hA5A5_0000_0000_0000 | 64'(i);
         tick();
      end
      bus.biu_ack_i = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();

      // Single read: immediate stb_ack, ack two cycles after issue.
      bus.biu_stb_ack_i = 1'b1;
      set_req(1'b0, 64'h40, 64'h0, 1'b0);
      tick();
      bus.req_valid_i = 1'b0;
      repeat (2) tick();
      bus.biu_ack_i = 1'b1;
      bus.biu_q_i   = 64'hDEAD_BEEF;
      tick();
      bus.biu_ack_i = 1'b0;
      repeat (2) tick();

      // Fill with stb_ack held low; fifth push is refused.
      bus.biu_stb_ack_i = 1'b0;
      for (int unsigned k = 0; k < 5; k++) begin
         set_req(1'b1, 64'h100 + 64'(k), 64'h1111_0000 + 64'(k), 1'b0);
         tick();
      end
      bus.req_valid_i = 1'b0;
      repeat (3) tick();
      drain(14);

      // Outstanding cap, then a single ack frees a slot.
      bus.biu_stb_ack_i = 1'b1;
      for (int unsigned k = 0; k < 3; k++) begin
         set_req(1'b0, 64'h200 + 64'(k), 64'h0, 1'b0);
         tick();
      end
      bus.req_valid_i = 1'b0;
      repeat (4) tick();
      bus.biu_ack_i = 1'b1;
      bus.biu_q_i   = 64'h0123_4567_89AB_CDEF;
      tick();
      bus.biu_ack_i = 1'b0;
      repeat (2) tick();
      drain(8);

      // Error on a read, with ack raised at the same time.
      set_req(1'b0, 64'h300, 64'h0, 1'b0);
      tick();
      bus.req_valid_i = 1'b0;
      tick();
      bus.biu_err_i = 1'b1;
      bus.biu_ack_i = 1'b1;
      bus.biu_q_i   = 64'h1234;
      tick();
      bus.biu_err_i = 1'b0;
      bus.biu_ack_i = 1'b0;
      repeat (2) tick();

      // Locked request behind an outstanding one.
      bus.biu_stb_ack_i = 1'b1;
      set_req(1'b1, 64'h400, 64'h55, 1'b0);
      tick();
      set_req(1'b0, 64'h408, 64'h0, 1'b1);
      tick();
      bus.req_valid_i = 1'b0;
      repeat (3) tick();
      drain(6);

      // Spurious ack with nothing outstanding; flag sticks until reset.
      bus.biu_ack_i = 1'b1;
      tick();
      bus.biu_ack_i = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();

      // Reset with one outstanding and three queued.
      bus.biu_stb_ack_i = 1'b1;
      set_req(1'b0, 64'h500, 64'h0, 1'b0);
      tick();
      bus.req_valid_i = 1'b0;
      tick();
      bus.biu_stb_ack_i = 1'b0;
      for (int unsigned k = 0; k < 3; k++) begin
         set_req(1'b1, 64'h600 + 64'(k), 64'(k), 1'b0);
         tick();
      end
      bus.req_valid_i = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      bus.biu_ack_i = 1'b1;
      tick();
      bus.biu_ack_i = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();

      // Randomized traffic.
      for (int unsigned i = 0; i < 3000; i++) begin
         bus.req_valid_i   = ($urandom_range(0, 1) == 1);
         bus.req_we_i      = ($urandom_range(0, 1) == 1);
         bus.req_adr_i     = {$urandom, $urandom};
         bus.req_size_i    = 3'($urandom_range(0, 7));
         bus.req_prot_i    = 3'($urandom_range(0, 7));
         bus.req_lock_i    = ($urandom_range(0, 7) == 0);
         bus.req_d_i       = {$urandom, $urandom};
         bus.biu_stb_ack_i = ($urandom_range(0, 3) != 0);
         bus.biu_q_i       = {$urandom, $urandom};
         if (m_out.size() > 0) begin
            bus.biu_ack_i = ($urandom_range(0, 2) == 0);
            bus.biu_err_i = ($urandom_range(0, 5) == 0);
         end else begin
            bus.biu_ack_i = ($urandom_range(0, 199) == 0);
            bus.biu_err_i = 1'b0;
         end
         rst = ($urandom_range(0, 299) != 0);
         tick();
      end
      idle();
      rst = 1'b1;
      drain(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/peripheral_spram_tl_req_queue.md
Name: peripheral_spram_tl_req_queue

Overview:
Upstream request stage for the SPRAM TileLink BIU port. Buffers core memory requests in a FIFO and issues them one at a time on the biu_stb/biu_stb_ack strobe handshake. Tracks outstanding transfers and returns biu_ack/biu_err responses to the core in order. Its biu_* outputs connect directly to the SPRAM TL slave's biu_* inputs.

Parameters:
XLEN, 64, data width
PLEN, 64, address width
DEPTH, 4, request FIFO entries (power of 2, >=2)
MAX_OUT, 2, maximum issued-but-unacknowledged transfers (1..7)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
req_valid_i  in  1  core request valid
req_ready_o  out  1  queue can accept
req_we_i  in  1  write enable
req_adr_i  in  PLEN  address
req_size_i  in  3  transfer size
req_prot_i  in  3  protection
req_lock_i  in  1  locked access
req_d_i  in  XLEN  write data
rsp_valid_o  out  1  response strobe, 1 cycle
rsp_q_o  out  XLEN  read data
rsp_err_o  out  1  response was an error
biu_stb_o  out  1  strobe to slave
biu_stb_ack_i  in  1  slave accepted strobe
biu_d_ack_i  in  1  data ack (unused; no lint waiver)
biu_adri_o  out  PLEN  address
biu_size_o  out  3  size
biu_type_o  out  3  burst type, constant SINGLE (3'b000)
biu_prot_o  out  3  protection
biu_lock_o  out  1  lock
biu_we_o  out  1  write enable
biu_d_o  out  XLEN  write data
biu_q_i  in  XLEN  read data
biu_ack_i  in  1  transfer ack
biu_err_i  in  1  transfer error
outstanding_o  out  3  issued, unacknowledged count
proto_err_o  out  1  sticky: response with nothing outstanding

Behaviour:
- Reset (rst==0 at clk edge): FIFO empty; outstanding=0; req_ready_o=1; biu_stb_o=0; rsp_valid_o=0; rsp_q_o=0; rsp_err_o=0; proto_err_o=0; all biu_* data outputs 0. Mid-transfer reset discards queued and outstanding requests; late acks after reset set proto_err_o.
- Push: req_valid_i & req_ready_o at edge writes entry {we,adr,size,prot,lock,d}. req_ready_o = !full (registered count; no same-cycle bypass when full, even if a pop occurs).
- Issue: biu_stb_o = !empty & (outstanding < MAX_OUT); biu_* fields driven from FIFO head, held stable while biu_stb_o & !biu_stb_ack_i.
- Pop: biu_stb_o & biu_stb_ack_i at edge pops head, outstanding+1.
- Latency: request pushed at edge N is presented at biu_stb_o in cycle N+1 (empty queue, outstanding<MAX_OUT).
- Response: (biu_ack_i | biu_err_i) with outstanding>0 → next cycle rsp_valid_o=1, rsp_q_o=biu_q_i (zero on writes/errors), rsp_err_o=biu_err_i; outstanding-1. ack and err together count as error.
- Simultaneous pop and response: outstanding unchanged.
- Response with outstanding==0: ignored (no rsp_valid_o), proto_err_o set until reset.
- FIFO pointers log2(DEPTH) bits, wrap naturally; count log2(DEPTH)+1 bits.
- Lock: while head has lock=1 and outstanding>0, stall issue until outstanding==0 (locked access issued alone).

Decomposition:
- peripheral_biu_pkg: SINGLE burst constant and req_entry_t packed struct {we, adr, size, prot, lock, d}.
- One sub-module: peripheral_spram_tl_req_fifo (generic sync FIFO: push/pop/full/empty/count, synchronous active-low reset).

Test Plan:
- Single read: push adr=0x40 we=0; slave stb_ack at once, ack 2 cycles later with q=0xDEADBEEF → biu_stb_o in cycle N+1, rsp_valid_o one cycle after ack, rsp_q_o=0xDEADBEEF, rsp_err_o=0.
- Fill: hold stb_ack=0, push 4 writes → req_ready_o=0 after the 4th; 5th push refused; head fields stable throughout.
- Outstanding cap: MAX_OUT=2, stb_ack always 1, no acks → exactly 2 pops, biu_stb_o drops, outstanding_o=2; one ack → third issue next cycle.
- Error: biu_err_i=1 on a read → rsp_valid_o=1, rsp_err_o=1, rsp_q_o=0, outstanding_o decrements.
- Spurious ack with outstanding=0 → no rsp_valid_o, proto_err_o=1 held until rst low.
- Reset mid-burst: rst low with 3 queued and 1 outstanding → next cycle biu_stb_o=0, outstanding_o=0, req_ready_o=1.
